dom_capture: RTL and testbench
==============================

# dom_capture

Receiving end of the CNN output-memory (DOM) write interface. Captures the `dom_address`/`dom_data`/`dom_ready` write stream from `cnn` into an 8-entry buffer with per-entry valid bits. On `finish` it drains all entries in address order over a valid/ready stream to the host. It sits between `cnn` and the top-level host port in `MyDesign`, and it flags protocol errors: overwrite, missing entry, and writes during drain.

## Interface
- `DATA_WIDTH`, default 16: DOM word width.
- `ADDR_WIDTH`, default 3: DOM address width; depth is `2**ADDR_WIDTH` (8).
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `dom_address`  in  ADDR_WIDTH  write address from `cnn`.
- `dom_data`  in  DATA_WIDTH  write data from `cnn`.
- `dom_ready`  in  1  write strobe; one write per cycle while high.
- `finish`  in  1  single-cycle pulse from `cnn`; the results are complete.
- `out_valid`  out  1  drain word available.
- `out_ready`  in  1  host accepts the word.
- `out_data`  out  DATA_WIDTH  drained word (0 if the entry was never written).
- `out_index`  out  ADDR_WIDTH  address of `out_data`.
- `out_last`  out  1  high with the entry at index DEPTH-1.
- `busy`  out  1  high in COLLECT or DRAIN.
- `overwrite_err`  out  1  sticky: an entry was written twice in one collection.
- `missing_err`  out  1  sticky: an unwritten entry was drained.
- `drop_err`  out  1  sticky: `dom_ready` was asserted during DRAIN.

## Operation
- States: IDLE, COLLECT, DRAIN. Reset state is IDLE.
- Reset values: all outputs 0, buffer contents 0, valid bits 0, read index 0.
- IDLE and COLLECT behave the same for writes. When `dom_ready` is high, `mem[dom_address] <= dom_data` and `vld[dom_address] <= 1`.
  - If `vld` is already set, set `overwrite_err`. The new data still replaces the old.
- IDLE -> COLLECT on the first `dom_ready`.
- IDLE or COLLECT -> DRAIN on `finish`. An empty IDLE drain is legal: all entries drain as 0 and `missing_err` is set.
- `dom_ready` and `finish` in the same cycle: the write is committed, and the state moves to DRAIN.
- In DRAIN:
  - `out_valid=1`, `out_index=rd_idx`, `out_data = vld[rd_idx] ? mem[rd_idx] : 0`.
  - On handshake (`out_valid & out_ready`): `rd_idx` increments. If `vld[rd_idx]` is 0, set `missing_err` at that handshake.
  - Handshake at index DEPTH-1 (`out_last`): return to IDLE, clear all `vld`, set `rd_idx` to 0. `mem` is not cleared.
  - `dom_ready` in DRAIN: the write is ignored and `drop_err` is set.
  - `finish` in DRAIN: ignored.
- Error flags are sticky until `reset`.
- `busy` = (state != IDLE).
- No arithmetic on data. `rd_idx` is ADDR_WIDTH bits and wraps naturally from DEPTH-1 to 0.

## Timing
- A write sampled at edge k is visible in `mem`/`vld` after edge k. It can be drained in the first DRAIN cycle.
- `finish` sampled at edge k: DRAIN, `out_valid=1` and `busy` are in effect from edge k onward. Latency from finish to the first word is 1 cycle.
- Throughput is 1 word per cycle with `out_ready` held high. A full drain takes DEPTH cycles; `out_valid` drops after the edge that accepts `out_last`.
- While `out_valid & !out_ready`, `out_data`, `out_index` and `out_last` hold stable. `out_valid` never deasserts without a handshake, except on reset.
- Back-to-back: a `dom_ready` in the cycle right after the final handshake is accepted (IDLE -> COLLECT).
- Mid-operation reset: all state returns to reset values asynchronously. Partial drains are discarded.
- Sticky errors rise on the edge after the offending cycle.

## Structure
- Shared package `cnn_pkg`:
  - `DOM_DATA_WIDTH=16`, `DOM_ADDR_WIDTH=3`, `DOM_DEPTH=8`.
  - State encoding `DOMC_IDLE=2'd0`, `DOMC_COLLECT=2'd1`, `DOMC_DRAIN=2'd2`.
- Sub-module `dom_regfile_8x16`: asynchronously reset 8x16 storage with a valid-bit vector.
  - One write port with an address/write-enable pair; one combinational read port; a bulk valid-clear input.
  - Note the `8x16` suffix: it keeps the name distinct from the existing 9x16 file.
- Top level contains the FSM, `rd_idx` counter, error flags and output muxing.

## Test plan
- Full frame: write addr 0..7 with data 16'h0100+addr, then pulse `finish`, with `out_ready`=1 throughout.
  - Expected: 8 consecutive words 0100..0107, `out_last` only on index 7, then IDLE. No error flags.
- Backpressure: same frame with `out_ready` toggling 1,0,0,1,...
  - Expected: `out_data` and `out_index` stable during each stall. Order is 0..7 and no word is duplicated.
- Overwrite and missing: write addr 2 = 16'h1111, then addr 2 = 16'h2222, skip addr 5, then `finish`.
  - Expected: index 2 drains as 2222, index 5 drains as 0, and both `overwrite_err` and `missing_err` are 1.
- Same-cycle event: assert `dom_ready` (addr 7, 16'hBEEF) together with `finish`.
  - Expected: DRAIN begins next cycle and index 7 drains as BEEF.
- Drain intrusion and reset: assert `dom_ready` during DRAIN, then assert `reset` after 3 handshakes.
  - Expected: `drop_err`=1 and the buffer is unchanged. After reset, all outputs are 0 and the state is IDLE.
- Empty finish: pulse `finish` from IDLE.
  - Expected: 8 zero words, `missing_err`=1, and `out_last` on index 7.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN definitions: DOM geometry and dom_capture state encoding.
package cnn_pkg;

  localparam int DOM_DATA_WIDTH = 16;
  localparam int DOM_ADDR_WIDTH = 3;
  localparam int DOM_DEPTH      = 8;

  typedef enum logic [1:0] {
    DOMC_IDLE    = 2'd0,
    DOMC_COLLECT = 2'd1,
    DOMC_DRAIN   = 2'd2
  } domc_state_e;

endpackage : cnn_pkg

// File: rtl/dom_regfile_8x16.sv
// DOM capture storage: data words plus one valid bit per entry.
// One write port, one combinational read port, bulk valid clear.
module dom_regfile_8x16
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = DOM_DATA_WIDTH,
  parameter int ADDR_WIDTH = DOM_ADDR_WIDTH
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        we_i,
  input  logic [ADDR_WIDTH-1:0]       waddr_i,
  input  logic [DATA_WIDTH-1:0]       wdata_i,
  input  logic                        clr_vld_i,
  input  logic [ADDR_WIDTH-1:0]       raddr_i,
  output logic [DATA_WIDTH-1:0]       rdata_o,
  output logic                        rvld_o,
  output logic [(2**ADDR_WIDTH)-1:0]  vld_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]      vld_q;

  // Storage update; a write in the same cycle as a clear keeps its own valid bit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      vld_q <= '0;
    end else begin
      if (clr_vld_i) begin
        vld_q <= '0;
      end
      if (we_i) begin
        mem_q[waddr_i] <= wdata_i;
        vld_q[waddr_i] <= 1'b1;
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];
  assign rvld_o  = vld_q[raddr_i];
  assign vld_o   = vld_q;

endmodule : dom_regfile_8x16

// File: rtl/dom_capture.sv
// dom_capture: collects the cnn DOM write stream into an 8-entry buffer and,
// on finish, drains every entry in address order over a valid/ready port.
// Overwrites, unwritten entries and writes during drain raise sticky flags.
module dom_capture
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = DOM_DATA_WIDTH,
  parameter int ADDR_WIDTH = DOM_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] dom_address,
  input  logic [DATA_WIDTH-1:0] dom_data,
  input  logic                  dom_ready,
  input  logic                  finish,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  out_last,
  output logic                  busy,
  output logic                  overwrite_err,
  output logic                  missing_err,
  output logic                  drop_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  domc_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_idx_q, rd_idx_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [ADDR_WIDTH-1:0] out_index_q, out_index_d;
  logic                  out_last_q, out_last_d;
  logic                  cur_vld_q, cur_vld_d;   // valid bit of the word being presented
  logic                  busy_q, busy_d;
  logic                  ow_q, ow_d;
  logic                  miss_q, miss_d;
  logic                  drop_q, drop_d;

  logic                  wr_en_s;
  logic                  hs_s;
  logic                  last_hs_s;
  logic                  bypass_s;
  logic [DATA_WIDTH-1:0] rf_rdata_s;
  logic                  rf_rvld_s;
  logic [DEPTH-1:0]      rf_vld_s;

  // The read port looks ahead at the next index so the output word can be registered.
  dom_regfile_8x16 #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_regfile (
    .clk_i     (clock),
    .rst_i     (reset),
    .we_i      (wr_en_s),
    .waddr_i   (dom_address),
    .wdata_i   (dom_data),
    .clr_vld_i (last_hs_s),
    .raddr_i   (rd_idx_d),
    .rdata_o   (rf_rdata_s),
    .rvld_o    (rf_rvld_s),
    .vld_o     (rf_vld_s)
  );

  // Next-state, read index and sticky error flags.
  always_comb begin
    state_d   = state_q;
    rd_idx_d  = rd_idx_q;
    ow_d      = ow_q;
    miss_d    = miss_q;
    drop_d    = drop_q;
    wr_en_s   = 1'b0;
    hs_s      = out_valid_q & out_ready;
    last_hs_s = hs_s & out_last_q;
    case (state_q)
      DOMC_IDLE: begin
        wr_en_s = dom_ready;
        if (finish) begin
          state_d = DOMC_DRAIN;
        end else if (dom_ready) begin
          state_d = DOMC_COLLECT;
        end else begin
          state_d = DOMC_IDLE;
        end
      end
      DOMC_COLLECT: begin
        wr_en_s = dom_ready;
        if (finish) begin
          state_d = DOMC_DRAIN;
        end else begin
          state_d = DOMC_COLLECT;
        end
      end
      DOMC_DRAIN: begin
        if (last_hs_s) begin
          state_d  = DOMC_IDLE;
          rd_idx_d = '0;
        end else if (hs_s) begin
          rd_idx_d = rd_idx_q + ADDR_WIDTH'(1);
        end else begin
          rd_idx_d = rd_idx_q;
        end
        if (hs_s && !cur_vld_q) begin
          miss_d = 1'b1;
        end else begin
          miss_d = miss_q;
        end
        if (dom_ready) begin
          drop_d = 1'b1;
        end else begin
          drop_d = drop_q;
        end
      end
      default: begin
        state_d  = DOMC_IDLE;
        rd_idx_d = '0;
      end
    endcase
    if (wr_en_s && rf_vld_s[dom_address]) begin
      ow_d = 1'b1;
    end else begin
      ow_d = ow_q;
    end
  end

  // Next output word; a write coinciding with finish is forwarded since it is not yet stored.
  always_comb begin
    out_valid_d = 1'b0;
    out_index_d = '0;
    out_last_d  = 1'b0;
    out_data_d  = '0;
    cur_vld_d   = 1'b0;
    busy_d      = (state_d != DOMC_IDLE);
    bypass_s    = wr_en_s && (dom_address == rd_idx_d);
    if (state_d == DOMC_DRAIN) begin
      out_valid_d = 1'b1;
      out_index_d = rd_idx_d;
      out_last_d  = (rd_idx_d == LAST_IDX);
      if (bypass_s) begin
        out_data_d = dom_data;
        cur_vld_d  = 1'b1;
      end else if (rf_rvld_s) begin
        out_data_d = rf_rdata_s;
        cur_vld_d  = 1'b1;
      end else begin
        out_data_d = '0;
        cur_vld_d  = 1'b0;
      end
    end else begin
      out_valid_d = 1'b0;
    end
  end

  // State, index, registered outputs and error flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= DOMC_IDLE;
      rd_idx_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
      cur_vld_q   <= 1'b0;
      busy_q      <= 1'b0;
      ow_q        <= 1'b0;
      miss_q      <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_idx_q    <= rd_idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
      cur_vld_q   <= cur_vld_d;
      busy_q      <= busy_d;
      ow_q        <= ow_d;
      miss_q      <= miss_d;
      drop_q      <= drop_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_index     = out_index_q;
  assign out_last      = out_last_q;
  assign busy          = busy_q;
  assign overwrite_err = ow_q;
  assign missing_err   = miss_q;
  assign drop_err      = drop_q;

endmodule : dom_capture

// File: tb/tb_dom_capture.sv
// Self-checking bench for dom_capture: directed scenarios plus random traffic,
// all checked every cycle against a behavioural buffer model.
module tb_dom_capture;

  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  dom_address;
  logic [15:0] dom_data;
  logic        dom_ready;
  logic        finish;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [2:0]  out_index;
  logic        out_last;
  logic        busy;
  logic        overwrite_err;
  logic        missing_err;
  logic        drop_err;

  dom_capture dut (
    .clock         (clock),
    .reset         (reset),
    .dom_address   (dom_address),
    .dom_data      (dom_data),
    .dom_ready     (dom_ready),
    .finish        (finish),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_index     (out_index),
    .out_last      (out_last),
    .busy          (busy),
    .overwrite_err (overwrite_err),
    .missing_err   (missing_err),
    .drop_err      (drop_err)
  );

  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: buffer contents, written flags, drain pointer, sticky errors.
  logic [15:0] m_mem [DEPTH];
  bit          m_vld [DEPTH];
  bit          m_drain, m_coll;
  int          m_idx;
  bit          m_ow, m_miss, m_drop;

  // Words the DUT delivered on handshakes of the current scenario.
  logic [15:0] got_data [$];
  int          got_idx  [$];
  bit          got_last [$];
  logic [15:0] prev_data;
  logic [2:0]  prev_idx;
  logic        prev_last;

  initial begin
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        for (int i = 0; i < DEPTH; i++) begin m_mem[i] = 16'h0; m_vld[i] = 0; end
        m_drain = 0; m_coll = 0; m_idx = 0; m_ow = 0; m_miss = 0; m_drop = 0;
      end else if (m_drain) begin
        if (dom_ready) m_drop = 1;
        if (out_ready) begin
          got_data.push_back(prev_data);
          got_idx.push_back(int'(prev_idx));
          got_last.push_back(prev_last);
          if (!m_vld[m_idx]) m_miss = 1;
          if (m_idx == DEPTH - 1) begin
            m_drain = 0; m_coll = 0; m_idx = 0;
            for (int i = 0; i < DEPTH; i++) m_vld[i] = 0;
          end else begin
            m_idx++;
          end
        end
      end else begin
        if (dom_ready) begin
          if (m_vld[dom_address]) m_ow = 1;
          m_mem[dom_address] = dom_data;
          m_vld[dom_address] = 1;
          m_coll = 1;
        end
        if (finish) begin
          m_drain = 1; m_coll = 0; m_idx = 0;
        end
      end
      #1;
      chk("out_valid", out_valid, m_drain);
      chk("busy", busy, m_drain | m_coll);
      chk("overwrite_err", overwrite_err, m_ow);
      chk("missing_err", missing_err, m_miss);
      chk("drop_err", drop_err, m_drop);
      if (m_drain) begin
        chk("out_index", out_index, m_idx);
        chk("out_data", out_data, m_vld[m_idx] ? m_mem[m_idx] : 16'h0);
        chk("out_last", out_last, m_idx == DEPTH - 1);
      end
      prev_data = out_data;
      prev_idx  = out_index;
      prev_last = out_last;
    end
  end

  task automatic clear_log();
    got_data.delete(); got_idx.delete(); got_last.delete();
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    dom_ready = 1'b1; dom_address = a; dom_data = d;
    @(negedge clock);
    dom_ready = 1'b0;
  endtask

  task automatic fin();
    finish = 1'b1;
    @(negedge clock);
    finish = 1'b0;
  endtask

  task automatic frame();
    for (int a = 0; a < DEPTH; a++) wr(3'(a), 16'h0100 + 16'(a));
  endtask

  // mode 0: ready always high; mode 1: ready pattern 1,0,0,1,0,0...
  task automatic drain(input int mode);
    int n = 0;
    do begin
      out_ready = (mode == 0) ? 1'b1 : ((n % 3) == 0);
      @(negedge clock);
      n++;
    end while (out_valid && n < 100);
    chk("drain_completes", out_valid, 1'b0);
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic check_frame(input string tag);
    chk({tag, "_count"}, got_data.size(), DEPTH);
    for (int i = 0; i < DEPTH && i < got_data.size(); i++) begin
      chk({tag, "_data"}, got_data[i], 16'h0100 + 16'(i));
      chk({tag, "_index"}, got_idx[i], i);
      chk({tag, "_last"}, got_last[i], i == DEPTH - 1);
    end
  endtask

  initial begin
    reset = 1'b1; dom_address = 3'd0; dom_data = 16'h0; dom_ready = 1'b0;
    finish = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 16'h0);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b0;
    @(negedge clock);

    // Full frame with ready held high
    clear_log(); frame(); fin(); drain(0);
    check_frame("full");
    chk("full_ow", overwrite_err, 1'b0);
    chk("full_miss", missing_err, 1'b0);
    chk("full_busy", busy, 1'b0);

    // Same frame under backpressure
    clear_log(); frame(); fin(); drain(1);
    check_frame("bp");

    // Overwrite at 2, address 5 never written
    clear_log();
    wr(3'd2, 16'h1111); wr(3'd2, 16'h2222);
    for (int a = 0; a < DEPTH; a++) if (a != 2 && a != 5) wr(3'(a), 16'h0100 + 16'(a));
    fin(); drain(0);
    chk("ovr_cnt", got_data.size(), DEPTH);
    if (got_data.size() == DEPTH) begin
      chk("ovr_idx2", got_data[2], 16'h2222);
      chk("ovr_idx5", got_data[5], 16'h0);
    end
    chk("ovr_ow", overwrite_err, 1'b1);
    chk("ovr_miss", missing_err, 1'b1);
    do_reset();

    // Write coinciding with finish
    clear_log();
    wr(3'd0, 16'h0A0A);
    dom_ready = 1'b1; dom_address = 3'd7; dom_data = 16'hBEEF; finish = 1'b1;
    @(negedge clock);
    dom_ready = 1'b0; finish = 1'b0;
    chk("same_valid", out_valid, 1'b1);
    drain(0);
    chk("same_cnt", got_data.size(), DEPTH);
    if (got_data.size() == DEPTH) begin
      chk("same_idx7", got_data[7], 16'hBEEF);
      chk("same_idx0", got_data[0], 16'h0A0A);
    end
    do_reset();

    // Write during drain, then reset after three handshakes
    clear_log(); frame(); fin();
    dom_ready = 1'b1; dom_address = 3'd1; dom_data = 16'hFFFF; out_ready = 1'b1;
    @(negedge clock);
    dom_ready = 1'b0;
    for (int n = 0; n < 20 && got_data.size() < 3; n++) @(negedge clock);
    chk("drop_hs", got_data.size(), 3);
    chk("drop_err", drop_err, 1'b1);
    if (got_data.size() >= 2) chk("drop_buf_unchanged", got_data[1], 16'h0101);
    reset = 1'b1; out_ready = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_data", out_data, 16'h0);
    chk("mid_rst_index", out_index, 3'd0);
    chk("mid_rst_drop", drop_err, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Empty finish from IDLE
    clear_log(); fin(); drain(0);
    chk("empty_cnt", got_data.size(), DEPTH);
    for (int i = 0; i < DEPTH && i < got_data.size(); i++) begin
      chk("empty_data", got_data[i], 16'h0);
      chk("empty_last", got_last[i], i == DEPTH - 1);
    end
    chk("empty_miss", missing_err, 1'b1);
    do_reset();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      dom_ready   = ($urandom % 2) == 0;
      dom_address = 3'($urandom);
      dom_data    = 16'($urandom);
      finish      = ($urandom % 16) == 0;
      out_ready   = ($urandom % 3) != 0;
      reset       = ($urandom % 500) == 0;
      @(negedge clock);
    end
    reset = 1'b0; dom_ready = 1'b0; finish = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_dom_capture
